// File: rtl/game_pkg.sv
// Shared game definitions: game-state encodings and score width used by
// the controller, score counter and obstacle blocks.
package game_pkg;

  localparam int SCORE_W = 16;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_RUN  = 2'd1,
    GS_OVER = 2'd2
  } gs_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counter-based debounce and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int TICKS = 4
) (
  input  logic counter_clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] count;

  // Any sample agreeing with the accepted level restarts the count, so only
  // an unbroken run of TICKS disagreeing samples moves the level.
  always_ff @(posedge counter_clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (count == CW'(TICKS - 1)) begin
          level <= sync2;
          count <= '0;
          press <= sync2;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: IDLE/RUN/OVER sequencing, jump and score-clear pulses,
// post-game-over press holdoff and high-score tracking.
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLDOFF_TICKS  = 64
) (
  input  logic               counter_clk,
  input  logic               reset,
  input  logic               btn,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score_bcd,
  output logic [1:0]         gs,
  output logic               halt,
  output logic               score_clear,
  output logic               jump,
  output logic [SCORE_W-1:0] hi_score_bcd,
  output logic               new_record
);

  localparam int HW = $clog2(HOLDOFF_TICKS + 1);

  gs_e                state;
  gs_e                next_state;
  logic [HW-1:0]      holdoff;
  logic [HW-1:0]      holdoff_next;
  logic               press;
  logic               clear_next;
  logic               jump_next;
  logic               record_next;
  logic [SCORE_W-1:0] hi_next;

  btn_debounce #(
    .TICKS(DEBOUNCE_TICKS)
  ) u_btn_debounce (
    .counter_clk(counter_clk),
    .reset      (reset),
    .btn        (btn),
    .press      (press)
  );

  // Collision is tested before press in RUN so a simultaneous press never jumps.
  always_comb begin
    next_state   = state;
    clear_next   = 1'b0;
    jump_next    = 1'b0;
    holdoff_next = holdoff;
    hi_next      = hi_score_bcd;
    record_next  = new_record;
    case (state)
      GS_IDLE: begin
        if (press) begin
          next_state = GS_RUN;
          clear_next = 1'b1;
        end
      end
      GS_RUN: begin
        if (collision) begin
          next_state   = GS_OVER;
          holdoff_next = HW'(HOLDOFF_TICKS);
          if (score_bcd > hi_score_bcd) begin
            hi_next     = score_bcd;
            record_next = 1'b1;
          end else begin
            record_next = 1'b0;
          end
        end else if (press) begin
          jump_next = 1'b1;
        end
      end
      GS_OVER: begin
        if (press && holdoff == '0) begin
          next_state  = GS_RUN;
          clear_next  = 1'b1;
          record_next = 1'b0;
        end else if (holdoff != '0) begin
          holdoff_next = holdoff - HW'(1);
        end
      end
      default: begin
        next_state  = GS_IDLE;
        record_next = 1'b0;
      end
    endcase
  end

  // halt is derived from the next state so it tracks gs in the same cycle.
  always_ff @(posedge counter_clk) begin
    if (reset) begin
      state        <= GS_IDLE;
      halt         <= 1'b1;
      score_clear  <= 1'b0;
      jump         <= 1'b0;
      holdoff      <= '0;
      hi_score_bcd <= '0;
      new_record   <= 1'b0;
    end else begin
      state        <= next_state;
      halt         <= (next_state != GS_RUN);
      score_clear  <= clear_next;
      jump         <= jump_next;
      holdoff      <= holdoff_next;
      hi_score_bcd <= hi_next;
      new_record   <= record_next;
    end
  end

  assign gs = state;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_game_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 64;

  logic        counter_clk = 1'b0;
  logic        reset;
  logic        btn;
  logic        collision;
  logic [15:0] score_bcd;
  logic [1:0]  gs;
  logic        halt;
  logic        score_clear;
  logic        jump;
  logic [15:0] hi_score_bcd;
  logic        new_record;

  int compared   = 0;
  int mismatched = 0;
  int clear_cnt  = 0;
  int jump_cnt   = 0;

  always #5 counter_clk = ~counter_clk;

  game_ctrl #(
    .DEBOUNCE_TICKS(DEB),
    .HOLDOFF_TICKS (HOLD)
  ) dut (
    .counter_clk (counter_clk),
    .reset       (reset),
    .btn         (btn),
    .collision   (collision),
    .score_bcd   (score_bcd),
    .gs          (gs),
    .halt        (halt),
    .score_clear (score_clear),
    .jump        (jump),
    .hi_score_bcd(hi_score_bcd),
    .new_record  (new_record)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic c, input logic [15:0] s, input int n);
    btn       = b;
    collision = c;
    score_bcd = s;
    repeat (n) @(negedge counter_clk);
  endtask

  // Behavioural model: btn history window for the debounce, game rules on top.
  bit        hist[$];
  bit        seen[$];
  bit        m_db, m_press, m_clear, m_jump, m_new;
  bit        model_valid = 1'b0;
  int        m_gs, m_hold;
  logic [15:0] m_hi;

  always @(posedge counter_clk) begin : model_p
    bit p;
    bit flip;
    bit np;
    if (reset) begin
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      seen.delete();
      m_db = 0; m_press = 0; m_clear = 0; m_jump = 0; m_new = 0;
      m_gs = 0; m_hold = 0; m_hi = 16'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      p = m_press;
      seen.push_back(hist[0]);
      if (seen.size() > DEB) void'(seen.pop_front());
      hist.push_back(btn);
      void'(hist.pop_front());
      flip = (seen.size() == DEB);
      foreach (seen[i]) if (seen[i] == m_db) flip = 1'b0;
      np = flip && !m_db;
      if (flip) m_db = !m_db;
      m_clear = 0;
      m_jump  = 0;
      case (m_gs)
        0: if (p) begin m_gs = 1; m_clear = 1; end
        1: begin
          if (collision) begin
            m_gs   = 2;
            m_hold = HOLD;
            m_new  = (score_bcd > m_hi);
            if (m_new) m_hi = score_bcd;
          end else if (p) begin
            m_jump = 1;
          end
        end
        default: begin
          if (p && m_hold == 0) begin
            m_gs = 1; m_clear = 1; m_new = 0;
          end else if (m_hold > 0) begin
            m_hold--;
          end
        end
      endcase
      m_press = np;
    end
  end

  always @(negedge counter_clk) begin
    if (model_valid) begin
      checkOutput("gs", 16'(gs), 16'(m_gs));
      checkOutput("halt", 16'(halt), 16'(m_gs != 1));
      checkOutput("score_clear", 16'(score_clear), 16'(m_clear));
      checkOutput("jump", 16'(jump), 16'(m_jump));
      checkOutput("hi_score_bcd", hi_score_bcd, m_hi);
      checkOutput("new_record", 16'(new_record), 16'(m_new));
    end
  end

  always @(negedge counter_clk) begin
    #1;
    if (score_clear === 1'b1) clear_cnt++;
    if (jump === 1'b1) jump_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] sc;
    logic        bl;
    int          run;
    reset = 1'b1; btn = 1'b0; collision = 1'b0; score_bcd = 16'h0;
    @(negedge counter_clk);
    applyStimulus(0, 0, 16'h0, 3);
    checkOutput("rst_gs", 16'(gs), 16'd0);
    checkOutput("rst_halt", 16'(halt), 16'd1);
    checkOutput("rst_clear", 16'(score_clear), 16'd0);
    checkOutput("rst_jump", 16'(jump), 16'd0);
    checkOutput("rst_hi", hi_score_bcd, 16'h0000);
    checkOutput("rst_new", 16'(new_record), 16'd0);
    reset = 1'b0;

    clear_cnt = 0;
    applyStimulus(1, 0, 16'h0, 3);
    applyStimulus(0, 0, 16'h0, 12);
    checkOutput("short_gs", 16'(gs), 16'd0);
    checkOutput("short_halt", 16'(halt), 16'd1);
    checkOutput("short_clear", 16'(clear_cnt), 16'd0);

    clear_cnt = 0; jump_cnt = 0;
    applyStimulus(1, 0, 16'h0, 10);
    applyStimulus(0, 0, 16'h0, 10);
    checkOutput("held_gs", 16'(gs), 16'd1);
    checkOutput("held_halt", 16'(halt), 16'd0);
    checkOutput("held_clear_cnt", 16'(clear_cnt), 16'd1);
    checkOutput("held_jump_cnt", 16'(jump_cnt), 16'd0);

    applyStimulus(0, 1, 16'h0099, 1);
    applyStimulus(0, 0, 16'h0099, 2);
    checkOutput("over1_gs", 16'(gs), 16'd2);
    checkOutput("over1_hi", hi_score_bcd, 16'h0099);

    applyStimulus(0, 0, 16'h0099, HOLD + 4);
    applyStimulus(1, 0, 16'h0099, 6);
    applyStimulus(0, 0, 16'h0099, 10);
    checkOutput("run2_gs", 16'(gs), 16'd1);
    applyStimulus(0, 1, 16'h0123, 1);
    applyStimulus(0, 0, 16'h0123, 1);
    checkOutput("rec_gs", 16'(gs), 16'd2);
    checkOutput("rec_hi", hi_score_bcd, 16'h0123);
    checkOutput("rec_new", 16'(new_record), 16'd1);

    for (int i = 0; i < 100 && m_hold != 16; i++) @(negedge counter_clk);
    checkOutput("wait_hold16", 16'(m_hold), 16'd16);
    clear_cnt = 0;
    applyStimulus(1, 0, 16'h0123, 6);
    applyStimulus(0, 0, 16'h0123, 3);
    checkOutput("ignored_gs", 16'(gs), 16'd2);
    checkOutput("ignored_clear", 16'(clear_cnt), 16'd0);
    for (int i = 0; i < 100 && m_hold != 0; i++) @(negedge counter_clk);
    checkOutput("wait_hold0", 16'(m_hold), 16'd0);
    clear_cnt = 0;
    applyStimulus(1, 0, 16'h0123, 6);
    applyStimulus(0, 0, 16'h0123, 10);
    checkOutput("restart_gs", 16'(gs), 16'd1);
    checkOutput("restart_clear", 16'(clear_cnt), 16'd1);
    checkOutput("restart_new", 16'(new_record), 16'd0);

    jump_cnt = 0;
    applyStimulus(1, 0, 16'h0123, 6);
    applyStimulus(1, 1, 16'h0123, 1);
    applyStimulus(0, 0, 16'h0123, 3);
    checkOutput("simul_gs", 16'(gs), 16'd2);
    checkOutput("simul_jump_cnt", 16'(jump_cnt), 16'd0);
    checkOutput("equal_new", 16'(new_record), 16'd0);
    checkOutput("equal_hi", hi_score_bcd, 16'h0123);

    applyStimulus(0, 0, 16'h0, HOLD + 4);
    applyStimulus(1, 0, 16'h0, 6);
    applyStimulus(0, 0, 16'h0, 10);
    checkOutput("run4_gs", 16'(gs), 16'd1);
    clear_cnt = 0; jump_cnt = 0;
    reset = 1'b1;
    applyStimulus(1, 1, 16'h0500, 2);
    checkOutput("midrst_gs", 16'(gs), 16'd0);
    checkOutput("midrst_halt", 16'(halt), 16'd1);
    checkOutput("midrst_hi", hi_score_bcd, 16'h0000);
    checkOutput("midrst_new", 16'(new_record), 16'd0);
    checkOutput("midrst_clear_cnt", 16'(clear_cnt), 16'd0);
    checkOutput("midrst_jump_cnt", 16'(jump_cnt), 16'd0);
    reset = 1'b0;
    applyStimulus(0, 0, 16'h0, 10);

    bl  = 1'b0;
    run = 0;
    sc  = 16'h0;
    for (int k = 0; k < 4000; k++) begin
      if (run == 0) begin
        bl  = ~bl;
        run = $urandom_range(1, 12);
      end
      run--;
      if ($urandom_range(0, 7) == 0)
        sc = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      reset = ($urandom_range(0, 399) == 0);
      applyStimulus(bl, ($urandom_range(0, 29) == 0), sc, 1);
    end
    reset = 1'b0;
    applyStimulus(0, 0, 16'h0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
